// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the load/store memory stage: memory actions, RISC-V
// load/store funct3 codes, FSM states and the access-size helper.
package mem_stage_lsu_pkg;

  localparam logic [1:0] MEM_ACTION_NONE  = 2'd0;
  localparam logic [1:0] MEM_ACTION_LOAD  = 2'd1;
  localparam logic [1:0] MEM_ACTION_STORE = 2'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Access size minus one; the low two funct3 bits encode log2(size) for
  // both loads and stores.
  function automatic logic [3:0] funct3_bytes_m1(input logic [2:0] funct3);
    logic [3:0] bytes_m1;
    case (funct3[1:0])
      2'd0:    bytes_m1 = 4'd0;
      2'd1:    bytes_m1 = 4'd1;
      2'd2:    bytes_m1 = 4'd3;
      default: bytes_m1 = 4'd7;
    endcase
    return bytes_m1;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe placement by address
// offset, and load data shift with sign/zero extension.
module mem_lane_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [OFF_W-1:0] st_off,
  input  logic [2:0]       st_funct3,
  input  logic [XLEN-1:0]  st_data,
  output logic [NB-1:0]    st_wstrb,
  output logic [XLEN-1:0]  st_wdata,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [2:0]       ld_funct3,
  input  logic [XLEN-1:0]  ld_rdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [3:0]      st_bytes_m1;
  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] st_masked;
  logic [XLEN-1:0] ld_shifted;

  assign st_bytes_m1 = funct3_bytes_m1(st_funct3);

  // Enable the low (size) byte lanes before shifting them into position.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign byte_en[gi]             = (4'(gi) <= st_bytes_m1);
    assign st_masked[gi*8 +: 8]    = byte_en[gi] ? st_data[gi*8 +: 8] : 8'h00;
  end

  assign st_wstrb   = byte_en << st_off;
  assign st_wdata   = st_masked << {st_off, 3'b000};
  assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = '0;
    case (ld_funct3)
      FUNCT3_LB:  ld_data = XLEN'(signed'(ld_shifted[7:0]));
      FUNCT3_LH:  ld_data = XLEN'(signed'(ld_shifted[15:0]));
      FUNCT3_LW:  ld_data = XLEN'(signed'(ld_shifted[31:0]));
      FUNCT3_LD:  ld_data = ld_shifted;
      FUNCT3_LBU: ld_data = XLEN'(ld_shifted[7:0]);
      FUNCT3_LHU: ld_data = XLEN'(ld_shifted[15:0]);
      FUNCT3_LWU: ld_data = XLEN'(ld_shifted[31:0]);
      default:    ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store memory stage: accepts one executed instruction, performs at most
// one DCache access for it and hands the result to write-back.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int RIDX_W      = 5,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ex_req,
  output logic              o_ex_ack,
  input  logic [1:0]        i_memaction,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_op2,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_inst,
  input  logic [RIDX_W-1:0] i_rd,
  input  logic              i_rd_wen,
  input  logic [XLEN-1:0]   i_rd_wdata,
  input  logic              i_nocmt,
  input  logic              i_skipcmt,
  output logic              o_wb_req,
  input  logic              i_wb_ack,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_inst,
  output logic [RIDX_W-1:0] o_rd,
  output logic              o_rd_wen,
  output logic [XLEN-1:0]   o_rd_wdata,
  output logic              o_nocmt,
  output logic              o_skipcmt,
  output logic              o_misalign,
  output logic              o_dcache_req,
  output logic [ADDR_W-1:0] o_dcache_addr,
  output logic              o_dcache_op,
  output logic [3:0]        o_dcache_bytes,
  output logic [XLEN/8-1:0] o_dcache_wstrb,
  output logic [XLEN-1:0]   o_dcache_wdata,
  input  logic              i_dcache_ack,
  input  logic [XLEN-1:0]   i_dcache_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t state_reg;

  // Instruction fields held while the DCache access is outstanding.
  logic [2:0]        funct3_reg;
  logic [OFF_W-1:0]  off_reg;
  logic              is_load_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       inst_reg;
  logic [RIDX_W-1:0] rd_reg;
  logic              rd_wen_reg;
  logic [XLEN-1:0]   rd_wdata_reg;
  logic              nocmt_reg;
  logic              skipcmt_reg;

  logic              wb_req_reg;
  logic [ADDR_W-1:0] res_pc_reg;
  logic [31:0]       res_inst_reg;
  logic [RIDX_W-1:0] res_rd_reg;
  logic              res_rd_wen_reg;
  logic [XLEN-1:0]   res_rd_wdata_reg;
  logic              res_nocmt_reg;
  logic              res_skipcmt_reg;
  logic              res_misalign_reg;

  logic              dc_req_reg;
  logic [ADDR_W-1:0] dc_addr_reg;
  logic              dc_op_reg;
  logic [3:0]        dc_bytes_reg;
  logic [NB-1:0]     dc_wstrb_reg;
  logic [XLEN-1:0]   dc_wdata_reg;

  logic            accept;
  logic            is_load_in;
  logic            is_store_in;
  logic [3:0]      bytes_m1_in;
  logic            misaligned_in;
  logic            illegal_in;
  logic            fault_in;
  logic [NB-1:0]   st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;

  assign o_ex_ack = (state_reg == ST_IDLE) | ((state_reg == ST_RESP) & i_wb_ack);
  assign accept   = i_ex_req & o_ex_ack;

  assign is_load_in    = (i_memaction == MEM_ACTION_LOAD);
  assign is_store_in   = (i_memaction == MEM_ACTION_STORE);
  assign bytes_m1_in   = funct3_bytes_m1(i_funct3);
  assign misaligned_in = (i_addr[2:0] & bytes_m1_in[2:0]) != 3'b000;
  assign illegal_in    = (XLEN == 32) &&
                         ((is_load_in && (i_funct3 == FUNCT3_LD || i_funct3 == FUNCT3_LWU)) ||
                          (is_store_in && i_funct3 == FUNCT3_SD));
  assign fault_in      = (ALIGN_CHECK != 0) && (is_load_in || is_store_in) &&
                         (misaligned_in || illegal_in);

  mem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .st_off    (i_addr[OFF_W-1:0]),
    .st_funct3 (i_funct3),
    .st_data   (i_op2),
    .st_wstrb  (st_wstrb),
    .st_wdata  (st_wdata),
    .ld_off    (off_reg),
    .ld_funct3 (funct3_reg),
    .ld_rdata  (i_dcache_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      funct3_reg       <= '0;
      off_reg          <= '0;
      is_load_reg      <= 1'b0;
      pc_reg           <= '0;
      inst_reg         <= '0;
      rd_reg           <= '0;
      rd_wen_reg       <= 1'b0;
      rd_wdata_reg     <= '0;
      nocmt_reg        <= 1'b0;
      skipcmt_reg      <= 1'b0;
      wb_req_reg       <= 1'b0;
      res_pc_reg       <= '0;
      res_inst_reg     <= '0;
      res_rd_reg       <= '0;
      res_rd_wen_reg   <= 1'b0;
      res_rd_wdata_reg <= '0;
      res_nocmt_reg    <= 1'b0;
      res_skipcmt_reg  <= 1'b0;
      res_misalign_reg <= 1'b0;
      dc_req_reg       <= 1'b0;
      dc_addr_reg      <= '0;
      dc_op_reg        <= 1'b0;
      dc_bytes_reg     <= '0;
      dc_wstrb_reg     <= '0;
      dc_wdata_reg     <= '0;
    end else begin
      case (state_reg)
        ST_ACCESS: begin
          if (i_dcache_ack) begin
            state_reg        <= ST_RESP;
            dc_req_reg       <= 1'b0;
            dc_addr_reg      <= '0;
            dc_op_reg        <= 1'b0;
            dc_bytes_reg     <= '0;
            dc_wstrb_reg     <= '0;
            dc_wdata_reg     <= '0;
            wb_req_reg       <= 1'b1;
            res_pc_reg       <= pc_reg;
            res_inst_reg     <= inst_reg;
            res_rd_reg       <= rd_reg;
            res_rd_wen_reg   <= rd_wen_reg;
            res_rd_wdata_reg <= is_load_reg ? ld_data : rd_wdata_reg;
            res_nocmt_reg    <= nocmt_reg;
            res_skipcmt_reg  <= skipcmt_reg;
            res_misalign_reg <= 1'b0;
          end
        end
        ST_RESP: begin
          // Results read as zero outside RESP; a same-cycle accept below
          // overrides this clear.
          if (i_wb_ack) begin
            state_reg        <= ST_IDLE;
            wb_req_reg       <= 1'b0;
            res_pc_reg       <= '0;
            res_inst_reg     <= '0;
            res_rd_reg       <= '0;
            res_rd_wen_reg   <= 1'b0;
            res_rd_wdata_reg <= '0;
            res_nocmt_reg    <= 1'b0;
            res_skipcmt_reg  <= 1'b0;
            res_misalign_reg <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        funct3_reg   <= i_funct3;
        off_reg      <= i_addr[OFF_W-1:0];
        is_load_reg  <= is_load_in;
        pc_reg       <= i_pc;
        inst_reg     <= i_inst;
        rd_reg       <= i_rd;
        rd_wen_reg   <= i_rd_wen;
        rd_wdata_reg <= i_rd_wdata;
        nocmt_reg    <= i_nocmt;
        skipcmt_reg  <= i_skipcmt;
        if (!(is_load_in || is_store_in) || fault_in) begin
          state_reg        <= ST_RESP;
          wb_req_reg       <= 1'b1;
          res_pc_reg       <= i_pc;
          res_inst_reg     <= i_inst;
          res_rd_reg       <= i_rd;
          res_rd_wen_reg   <= i_rd_wen & ~fault_in;
          res_rd_wdata_reg <= i_rd_wdata;
          res_nocmt_reg    <= i_nocmt;
          res_skipcmt_reg  <= i_skipcmt;
          res_misalign_reg <= fault_in;
        end else begin
          state_reg    <= ST_ACCESS;
          dc_req_reg   <= 1'b1;
          dc_addr_reg  <= i_addr;
          dc_op_reg    <= is_store_in;
          dc_bytes_reg <= bytes_m1_in;
          dc_wstrb_reg <= is_store_in ? st_wstrb : '0;
          dc_wdata_reg <= is_store_in ? st_wdata : '0;
        end
      end
    end
  end

  assign o_wb_req       = wb_req_reg;
  assign o_pc           = res_pc_reg;
  assign o_inst         = res_inst_reg;
  assign o_rd           = res_rd_reg;
  assign o_rd_wen       = res_rd_wen_reg;
  assign o_rd_wdata     = res_rd_wdata_reg;
  assign o_nocmt        = res_nocmt_reg;
  assign o_skipcmt      = res_skipcmt_reg;
  assign o_misalign     = res_misalign_reg;
  assign o_dcache_req   = dc_req_reg;
  assign o_dcache_addr  = dc_addr_reg;
  assign o_dcache_op    = dc_op_reg;
  assign o_dcache_bytes = dc_bytes_reg;
  assign o_dcache_wstrb = dc_wstrb_reg;
  assign o_dcache_wdata = dc_wdata_reg;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised load/store memory stage that sits between the execute and write-back stages.
- Latches one executed instruction through a req/ack handshake and drives at most one DCache access for it.
- Aligns load data by address offset with sign/zero extension; places store data on its byte lane with byte strobes.
- Detects misaligned and XLEN-illegal accesses, then presents the result to write-back with its own req/ack handshake.
- Accepts back-to-back instructions without a bubble when write-back acks.

Parameters:
XLEN, 64, data width; legal values 32 or 64
ADDR_W, 64, address width
RIDX_W, 5, register index width
ALIGN_CHECK, 1, 1 = flag misaligned accesses; 0 = pass them to DCache unchecked

Ports:
clk  in  1  clock
rst  in  1  reset
i_ex_req  in  1  execute has a valid instruction
o_ex_ack  out  1  stage accepts the instruction this cycle
i_memaction  in  2  0 NONE, 1 LOAD, 2 STORE
i_funct3  in  3  RISC-V load/store width code
i_addr  in  ADDR_W  effective address
i_op2  in  XLEN  store source data
i_pc  in  ADDR_W  instruction PC
i_inst  in  32  instruction word
i_rd  in  RIDX_W  destination register
i_rd_wen  in  1  destination write enable
i_rd_wdata  in  XLEN  ALU result, used when memaction is not LOAD
i_nocmt  in  1  no-commit flag, passed through
i_skipcmt  in  1  skip-commit flag, passed through
o_wb_req  out  1  result valid toward write-back
i_wb_ack  in  1  write-back accepts the result
o_pc, o_inst, o_rd, o_rd_wen, o_rd_wdata, o_nocmt, o_skipcmt  out  (matching input widths)  registered results
o_misalign  out  1  access faulted: misaligned, or illegal width for XLEN
o_dcache_req  out  1  DCache request
o_dcache_addr  out  ADDR_W  access address, unmodified
o_dcache_op  out  1  0 read, 1 write
o_dcache_bytes  out  4  access size minus 1: 0, 1, 3 or 7
o_dcache_wstrb  out  XLEN/8  byte-lane strobes
o_dcache_wdata  out  XLEN  lane-positioned store data
i_dcache_ack  in  1  DCache completes; rdata is valid in the same cycle
i_dcache_rdata  in  XLEN  lane-positioned read data

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - State returns to IDLE.
  - Every output is 0 except o_ex_ack, which is 1.
  - Reset in ACCESS drops o_dcache_req the next cycle; a late i_dcache_ack while in IDLE is ignored.
- FSM states: IDLE, ACCESS, RESP.
- o_ex_ack = (state==IDLE) | (state==RESP & i_wb_ack).
  - Handshake fires when i_ex_req & o_ex_ack; all inputs are registered that cycle.
- On accept:
  - memaction NONE, or a fault when ALIGN_CHECK=1 -> RESP.
  - Otherwise -> ACCESS.
- Fault on a LOAD or STORE:
  - Misaligned: addr[log2(size)-1:0] != 0.
  - Illegal width: XLEN=32 and funct3 is LD, LWU or SD.
  - Response: no DCache request, o_misalign=1, o_rd_wen=0.
- ACCESS:
  - o_dcache_req=1; addr, op, bytes, wstrb and wdata held stable until i_dcache_ack.
  - On ack: capture rdata, deassert req the next cycle, -> RESP.
- RESP:
  - o_wb_req=1; all o_* result signals held stable until i_wb_ack.
  - On i_wb_ack: -> IDLE, or directly to ACCESS/RESP when a new instruction is accepted in the same cycle.
- Result outputs read 0 whenever o_wb_req=0.
- Load data path:
  - off = addr[log2(XLEN/8)-1:0].
  - shifted = rdata >> (8*off).
  - LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD passes through.
  - Undefined funct3 yields 0.
- Store data path:
  - wdata = op2 low size bytes << (8*off); other lanes 0.
  - wstrb = ((1<<size)-1) << off.
- Non-LOAD rd_wdata: i_rd_wdata passed through.
- Latency:
  - NONE: accepted at cycle N -> o_wb_req at N+1.
  - LOAD/STORE: accepted at N -> o_dcache_req at N+1; ack at M -> o_wb_req at M+1.
- Throughput: with i_wb_ack held high, one NONE-type instruction per cycle.

Decomposition:
- Shared package holds:
  - MEM_ACTION_NONE/LOAD/STORE.
  - FUNCT3_LB..LWU and FUNCT3_SB..SD.
  - FSM state encoding.
  - Size-from-funct3 function.
- One sub-module, mem_lane_align: purely combinational; computes wstrb, store lane shift and load shift/extend, parametrised by XLEN.

Test Plan:
- LB with addr=0x1003, rdata=0x00000000_80000000 (XLEN=64) -> rd_wdata=0xFFFFFFFF_FFFFFF80; bytes=0.
- SH with addr=0x2006, op2=0x1234 -> wstrb=0xC0, wdata=0x1234_0000_0000_0000, bytes=1, op=1.
- LW with addr=0x3002, ALIGN_CHECK=1 -> no o_dcache_req; o_wb_req at the next cycle with o_misalign=1, o_rd_wen=0.
- Three back-to-back NONE instructions with i_wb_ack held at 1 -> o_wb_req high for 3 consecutive cycles carrying each rd_wdata.
- LD with DCache ack delayed 5 cycles and i_wb_ack delayed 3 cycles -> req/addr stable throughout, o_ex_ack=0 until the wb handshake.
- Assert rst while in ACCESS -> next cycle o_dcache_req=0 and o_ex_ack=1; a stray i_dcache_ack afterwards produces no o_wb_req.
